// File: rtl/sprite_mover.sv
// rtl/sprite_mover.sv - tile-map sprite mover on a req/ready map port; optional feature macro SPRITE_MOVER_COLLISION_EN
module sprite_mover #(
  parameter int MAP_W      = 40,
  parameter int MAP_H      = 30,
  parameter int COORD_W    = 6,
  parameter int FRAME_DIV  = 25,
  parameter int START_X    = 6,
  parameter int START_Y    = 6,
  parameter int BODY_CODE  = 2,
  parameter int BLANK_CODE = 3,
  parameter int EMPTY_CODE = 0,
  parameter int WALL_CODE  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame,
  input  logic                 activate,
  input  logic [7:0]           control,
  output logic [2*COORD_W-1:0] position,
  input  logic [7:0]           sprite_read,
  input  logic                 ready,
  output logic [7:0]           sprite_write,
  output logic                 write,
  output logic                 req,
  output logic                 moved,
  output logic                 blocked
);

  localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FRAME_DIV - 1);
  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(MAP_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(MAP_H - 1);
  localparam logic [COORD_W-1:0] X_START  = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] Y_START  = COORD_W'(START_Y);
  localparam logic [4:0]         BODY5    = 5'(BODY_CODE);
  localparam logic [7:0]         BLANK8   = 8'(BLANK_CODE);
  localparam logic [7:0]         EMPTY8   = 8'(EMPTY_CODE);
  localparam logic [7:0]         WALL8    = 8'(WALL_CODE);

  // Orientation codes double as the top bits of the visible sprite code
  localparam logic [1:0] OR_RIGHT = 2'd0;
  localparam logic [1:0] OR_UP    = 2'd1;
  localparam logic [1:0] OR_DOWN  = 2'd2;
  localparam logic [1:0] OR_LEFT  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    RD_TGT,
    CHECK,
    WR_NEW,
    WR_OLD,
    DRAW
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     frame_cnt;
  logic                 tick;
  logic                 tick_pending;
  logic [COORD_W-1:0]   x;
  logic [COORD_W-1:0]   y;
  logic [COORD_W-1:0]   tgt_x;
  logic [COORD_W-1:0]   tgt_y;
  logic [1:0]           orient;
  logic                 blink;

  logic                 dir_any;
  logic [1:0]           dir_orient;
  logic [COORD_W-1:0]   next_x;
  logic [COORD_W-1:0]   next_y;

  logic                 unused_inputs;

`ifdef SPRITE_MOVER_COLLISION_EN
  logic [7:0]           rd_code;
  logic                 blocked_r;

  assign blocked       = blocked_r;
  assign unused_inputs = ^{control[7:6], control[1:0]};
`else
  // Without collision the map is never read and no move is ever refused
  assign blocked       = 1'b0;
  assign unused_inputs = ^{control[7:6], control[1:0], sprite_read, WALL8};
`endif

  // Sprite code shown this tick: body with orientation, or blank in the off phase
  function automatic logic [7:0] visible_code(input logic [1:0] o, input logic b);
    visible_code = b ? {1'b0, o, BODY5} : BLANK8;
  endfunction

  // Frame divider: counts strobes only while the actor is active
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
    end else if (frame && activate) begin
      if (frame_cnt == CNT_LAST) begin
        frame_cnt <= '0;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign tick = frame && activate && (frame_cnt == CNT_LAST);

  // Direction decode with priority left > right > up > down and explicit edge wrap
  always_comb begin
    dir_any    = 1'b1;
    dir_orient = orient;
    next_x     = x;
    next_y     = y;
    if (control[5]) begin
      dir_orient = OR_LEFT;
      next_x     = (x == '0) ? X_LAST : x - 1'b1;
    end else if (control[4]) begin
      dir_orient = OR_RIGHT;
      next_x     = (x == X_LAST) ? '0 : x + 1'b1;
    end else if (control[3]) begin
      dir_orient = OR_UP;
      next_y     = (y == '0) ? Y_LAST : y - 1'b1;
    end else if (control[2]) begin
      dir_orient = OR_DOWN;
      next_y     = (y == Y_LAST) ? '0 : y + 1'b1;
    end else begin
      dir_any    = 1'b0;
    end
  end

  // Movement sequencer: owns the map port outputs, the sprite position and the one-deep tick latch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      x            <= X_START;
      y            <= Y_START;
      tgt_x        <= X_START;
      tgt_y        <= Y_START;
      orient       <= OR_RIGHT;
      blink        <= 1'b0;
      tick_pending <= 1'b0;
      position     <= {X_START, Y_START};
      sprite_write <= 8'h00;
      write        <= 1'b0;
      req          <= 1'b0;
      moved        <= 1'b0;
`ifdef SPRITE_MOVER_COLLISION_EN
      rd_code      <= 8'h00;
      blocked_r    <= 1'b0;
`endif
    end else begin
      moved <= 1'b0;
`ifdef SPRITE_MOVER_COLLISION_EN
      blocked_r <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (tick_pending && activate) begin
            tick_pending <= 1'b0;
            blink        <= ~blink;
            state        <= CALC;
          end
        end

        CALC: begin
          orient <= dir_orient;
          tgt_x  <= next_x;
          tgt_y  <= next_y;
          req    <= 1'b1;
          if (!dir_any) begin
            write        <= 1'b1;
            position     <= {x, y};
            sprite_write <= visible_code(dir_orient, blink);
            state        <= DRAW;
          end else begin
`ifdef SPRITE_MOVER_COLLISION_EN
            write        <= 1'b0;
            position     <= {next_x, next_y};
            state        <= RD_TGT;
`else
            write        <= 1'b1;
            position     <= {next_x, next_y};
            sprite_write <= visible_code(dir_orient, blink);
            state        <= WR_NEW;
`endif
          end
        end

`ifdef SPRITE_MOVER_COLLISION_EN
        RD_TGT: begin
          if (ready) begin
            rd_code <= sprite_read;
            req     <= 1'b0;
            state   <= CHECK;
          end
        end

        CHECK: begin
          req          <= 1'b1;
          write        <= 1'b1;
          sprite_write <= visible_code(orient, blink);
          if (rd_code == WALL8) begin
            // Refused move still redraws the sprite so the blink phase shows
            blocked_r <= 1'b1;
            position  <= {x, y};
            state     <= DRAW;
          end else begin
            position  <= {tgt_x, tgt_y};
            state     <= WR_NEW;
          end
        end
`endif

        WR_NEW: begin
          if (ready) begin
            position     <= {x, y};
            sprite_write <= EMPTY8;
            state        <= WR_OLD;
          end
        end

        WR_OLD: begin
          if (ready) begin
            x     <= tgt_x;
            y     <= tgt_y;
            moved <= 1'b1;
            req   <= 1'b0;
            write <= 1'b0;
            state <= IDLE;
          end
        end

        DRAW: begin
          if (ready) begin
            req   <= 1'b0;
            write <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          req   <= 1'b0;
          write <= 1'b0;
          state <= IDLE;
        end
      endcase

      // Ticks are latched only while idle; one arriving mid-sequence is dropped
      if (tick && (state == IDLE)) begin
        tick_pending <= 1'b1;
      end
    end
  end

endmodule

// File: doc/sprite_mover.md
Name: sprite_mover

Overview:
- Parametrised successor of the single-sprite game-object controller. Moves one sprite on a tile map of configurable size, once every FRAME_DIV frames.
- Talks to the map through a req/ready handshake with read-before-move collision checking, wrap-around at the map edges and a blinking sprite.
- Sits between the control-pad decoder and the map RAM arbiter. Several instances, one per actor, share one map port through the arbiter.

Parameters:
- MAP_W, 40, map width in tiles
- MAP_H, 30, map height in tiles
- COORD_W, 6, bits per coordinate (must hold MAP_W-1 and MAP_H-1)
- FRAME_DIV, 25, frames per movement tick (≥1)
- START_X, 6, reset x
- START_Y, 6, reset y
- BODY_CODE, 2, low 5 bits of the visible sprite code
- BLANK_CODE, 3, sprite code for the blink-off phase
- EMPTY_CODE, 0, code written to a vacated cell
- WALL_CODE, 1, map code that blocks movement

Ports:
- clk, in, 1, system clock
- reset, in, 1, asynchronous, active-low reset
- frame, in, 1, one-clk strobe per video frame, synchronous to clk
- activate, in, 1, enables ticks and map accesses
- control, in, 8, {unused, unused, left, right, up, down, btn1, btn2}
- position, out, 2*COORD_W, map address {x, y}
- sprite_read, in, 8, map data, valid when req && ready && !write
- ready, in, 1, map completes the access this cycle
- sprite_write, out, 8, code to write
- write, out, 1, 1 = write access, 0 = read access
- req, out, 1, map access request
- moved, out, 1, one-clk pulse: move committed
- blocked, out, 1, one-clk pulse: move refused by a wall

Behaviour:
- Reset (reset=0, async):
  - position={START_X,START_Y}; sprite_write=0; write=0; req=0; moved=0; blocked=0.
  - Internal state: x=START_X, y=START_Y, orientation=RIGHT, blink=0, frame counter=0, tick_pending=0, FSM=IDLE.
  - Reset mid-transaction drops req immediately. No partial write is retried.
- Frame counter:
  - Counts frame strobes from 0 to FRAME_DIV-1, but only while activate=1.
  - On the strobe at FRAME_DIV-1: counter returns to 0 and tick_pending is set.
  - Only one tick can be pending; further ticks arriving while the FSM is busy are dropped.
- Orientation codes: RIGHT=0, UP=1, DOWN=2, LEFT=3.
- Visible code: {orientation[2:0], BODY_CODE[4:0]} when blink=1, else BLANK_CODE.
- Handshake:
  - req, write, position and sprite_write are registered outputs and stay stable while req=1.
  - An access completes on the clk edge where req && ready. req deasserts the next cycle unless a new access is issued.
  - Each access takes at least 1 cycle. Stall length is unbounded.
- FSM states:
  - IDLE:
    - If tick_pending && activate: clear tick_pending, toggle blink, go to CALC.
  - CALC:
    - Decode direction with priority left > right > up > down; update orientation to match.
    - No direction pressed → DRAW.
    - Otherwise compute the target cell with wrap: x-1 at x=0 gives MAP_W-1; x+1 at MAP_W-1 gives 0; y wraps likewise on MAP_H.
    - Go to RD_TGT.
  - RD_TGT:
    - req=1, write=0, position=target.
    - On ready, latch sprite_read and go to CHECK.
  - CHECK:
    - Latched code == WALL_CODE → pulse blocked, go to DRAW.
    - Otherwise → WR_NEW.
  - WR_NEW:
    - req=1, write=1, position=target, sprite_write=visible code.
    - On ready → WR_OLD.
  - WR_OLD:
    - req=1, write=1, position=old {x,y}, sprite_write=EMPTY_CODE.
    - On ready: x,y take the target values, pulse moved, go to IDLE.
  - DRAW:
    - req=1, write=1, position={x,y}, sprite_write=visible code.
    - On ready → IDLE.
- activate falling mid-sequence: the current sequence runs to completion, then the FSM stays in IDLE.
- Arithmetic: x and y are unsigned COORD_W bits. Wrap is explicit; there is no signed-compare wrap.
- Latency with ready tied to 1: tick → RD_TGT issued 2 clks later. moved pulses 1 clk after the WR_OLD handshake.

Optional Feature:
- SPRITE_MOVER_COLLISION_EN:
  - Defined: RD_TGT and CHECK exist as described above.
  - Undefined: CALC goes straight to WR_NEW, so every move is committed. blocked is tied to 0 and sprite_read is unused.

Test Plan:
- Defaults, ready=1, activate=1, right=1, 25 frames → read at (7,6); write 8'h02 at (7,6); write 8'h00 at (6,6); moved pulse; position x ends at 7.
- Set x=0, left=1, one tick → target (39,6); write 8'h62 at (39,6) (or BLANK_CODE 8'h03 in the blink-off phase); 8'h00 at (0,6).
- sprite_read=8'h01 on the target read → blocked pulse; single write of the visible code at the current cell; x,y unchanged.
- ready held low 3 cycles on each access → req, position, write and sprite_write stable through the stall; exactly 3 accesses per tick; no duplicate completion.
- left=1 and right=1 together → orientation LEFT, target x-1. activate=0 for 100 frames → req never asserted, counter frozen.
- reset pulsed low during WR_NEW → req=0 asynchronously; position={6,6}; counter 0; first tick after release needs a full 25 frames.
